// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode seven-segment
// digits sharing one active-low 4-bit decoder. A shadow frame is loaded via a
// ready/load handshake and copied into the active frame only at the frame
// boundary, so a digit never shows a mix of old and new frames.
module display_scan_ctrl #(
  parameter int         NUM_DIGITS  = 4,
  parameter int         REFRESH_DIV = 50000,
  parameter int         GAP_CYCLES  = 2,
  parameter logic [3:0] BLANK_CODE  = 4'hF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_data_in,
  input  logic [NUM_DIGITS-1:0]   i_blank_in,
  input  logic                    i_lzb,
  output logic                    o_ready,
  output logic [3:0]              o_digit_code,
  output logic [NUM_DIGITS-1:0]   o_digit_en_n
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [4*NUM_DIGITS-1:0] BLANK_FRAME = {NUM_DIGITS{BLANK_CODE}};

  logic [DIV_W-1:0]        r_div_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic [4*NUM_DIGITS-1:0] r_sh_data;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic                    r_pending;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic                    w_accept;
  logic                    w_gap;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [3:0]              w_cur_nib;
  logic                    w_cur_blank;

  assign w_slot_end  = (r_div_cnt == DIV_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_accept    = i_load && !r_pending;

  // Slot divider and digit index; index steps once per slot and wraps per frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (w_slot_end) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Shadow capture on handshake, commit to the active frame at the boundary.
  // Commit needs pending=1 and capture needs pending=0, so they never collide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act_data  <= BLANK_FRAME;
      r_act_blank <= '0;
      r_sh_data   <= BLANK_FRAME;
      r_sh_blank  <= '0;
      r_pending   <= 1'b0;
    end else if (w_frame_end && r_pending) begin
      r_act_data  <= r_sh_data;
      r_act_blank <= r_sh_blank;
      r_pending   <= 1'b0;
    end else if (w_accept) begin
      r_sh_data   <= i_data_in;
      r_sh_blank  <= i_blank_in;
      r_pending   <= 1'b1;
    end
  end

  // Leading-zero detect: scan from the top digit down while nibbles stay zero.
  always_comb begin : lz_scan
    logic zero_run;
    zero_run = 1'b1;
    w_lz     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (r_act_data[4*k +: 4] == 4'h0);
      if (k != 0) w_lz[k] = i_lzb & zero_run;
    end
  end

  assign w_blank = r_act_blank | w_lz;

  // Select the nibble, blank flag and one-hot enable of the current digit.
  always_comb begin
    w_cur_nib   = '0;
    w_cur_blank = 1'b0;
    w_sel       = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_cur_nib   = r_act_data[4*k +: 4];
        w_cur_blank = w_blank[k];
        w_sel[k]    = 1'b1;
      end
    end
  end

  generate
    if (GAP_CYCLES == 0) begin : g_no_gap
      assign w_gap = 1'b0;
    end else begin : g_gap
      assign w_gap = (r_div_cnt < DIV_W'(GAP_CYCLES));
    end
  endgenerate

  assign o_ready      = ~r_pending;
  assign o_digit_code = (w_gap || w_cur_blank) ? BLANK_CODE : w_cur_nib;
  assign o_digit_en_n = w_gap ? '1 : ~w_sel;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a cycle-indexed reference model of
// the display timeline predicts ready/code/enables; a monitor compares them.
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  blank_in;
  logic        lzb;
  logic        ready;
  logic [3:0]  digit_code;
  logic [3:0]  digit_en_n;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .GAP_CYCLES (GC),
    .BLANK_CODE (4'hF)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_load      (load),
    .i_data_in   (data_in),
    .i_blank_in  (blank_in),
    .i_lzb       (lzb),
    .o_ready     (ready),
    .o_digit_code(digit_code),
    .o_digit_en_n(digit_en_n)
  );

  logic [8:0]  exp_q[$];
  logic [19:0] pend_q[$];
  int          m_t;
  logic [15:0] m_act_d;
  logic [3:0]  m_act_b;
  logic        cur_lzb;
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_on   = 1'b0;
  logic [8:0]  mon_e;
  logic [8:0]  mon_a;

  // Model: m_t counts clock edges since reset release; the displayed frame is
  // whatever was pending at the most recent multiple-of-FR edge.
  task automatic model_reset();
    m_t     = 0;
    m_act_d = 16'hFFFF;
    m_act_b = 4'h0;
    pend_q.delete();
  endtask

  task automatic model_edge();
    bit          boundary;
    logic [19:0] f;
    boundary = ((m_t % FR) == FR - 1);
    m_t++;
    if (boundary && pend_q.size() > 0) begin
      f       = pend_q.pop_front();
      m_act_d = f[19:4];
      m_act_b = f[3:0];
    end else if (load && pend_q.size() == 0) begin
      pend_q.push_back({data_in, blank_in});
    end
  endtask

  function automatic logic [8:0] expected();
    int         slot;
    int         pos;
    logic       rdy;
    logic       blk;
    logic [3:0] en;
    logic [3:0] code;
    slot = (m_t / RD) % ND;
    pos  = m_t % RD;
    rdy  = (pend_q.size() == 0);
    if (pos < GC) return {rdy, 4'hF, 4'hF};
    en   = ~(4'b0001 << slot);
    blk  = m_act_b[slot] || (lzb && slot > 0 && ((m_act_d >> (4*slot)) == 16'h0));
    code = blk ? 4'hF : m_act_d[4*slot +: 4];
    return {rdy, code, en};
  endfunction

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] b,
                      input logic z, input logic r);
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    load     = ld;
    data_in  = d;
    blank_in = b;
    lzb      = z;
    cur_lzb  = z;
    rst_n    = r;
    if (!r) model_reset();
    exp_q.push_back(expected());
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 4'h0, cur_lzb, 1'b1);
  endtask

  // Leaves the bench such that the next step's stimulus is sampled at an edge
  // whose pre-edge position in the frame is p.
  task automatic go_to(input int p);
    while (((m_t + 1) % FR) != p) idle(1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b);
    step(1'b1, d, b, cur_lzb, 1'b1);
  endtask

  // Monitor: every cycle the DUT presents a scan output, checked mid-cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty: got ready=%b code=%h en_n=%b, required a queued expectation",
                 ready, digit_code, digit_en_n);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = {ready, digit_code, digit_en_n};
        if (mon_a === mon_e) n_pass++;
        else $display("FAIL scan t=%0d: got ready=%b code=%h en_n=%b, required ready=%b code=%h en_n=%b",
                      m_t, mon_a[8], mon_a[7:4], mon_a[3:0], mon_e[8], mon_e[7:4], mon_e[3:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [3:0]  rb;
    logic        rz;
    rst_n    = 1'b0;
    load     = 1'b0;
    data_in  = 16'h0;
    blank_in = 4'h0;
    lzb      = 1'b0;
    cur_lzb  = 1'b0;
    model_reset();
    mon_on   = 1'b1;

    // Reset, idle scan, then a mid-slot reset and restart.
    repeat (2) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    idle(43);
    repeat (2) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    idle(70);

    // Load 1234 during digit 1; a second load while not ready is dropped.
    go_to(10);
    do_load(16'h1234, 4'h0);
    idle(3);
    do_load(16'h5678, 4'h0);
    idle(80);

    // Load on the frame-boundary edge with leading-zero blanking on.
    cur_lzb = 1'b1;
    go_to(31);
    do_load(16'h0042, 4'h0);
    idle(80);

    // All-zero frame under LZB, then a force-blank of digit 0.
    do_load(16'h0000, 4'h0);
    idle(70);
    do_load(16'h0042, 4'b0001);
    idle(70);
    cur_lzb = 1'b0;
    idle(40);

    // Reset while a 9999 frame is pending.
    go_to(5);
    do_load(16'h9999, 4'h0);
    idle(5);
    repeat (2) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    idle(80);

    // Randomised traffic: sparse loads, zero-heavy data, LZB toggles, rare resets.
    rz = 1'b0;
    repeat (3000) begin
      for (int i = 0; i < 4; i++)
        rd[4*i +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
      rb = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'h0;
      if ($urandom_range(63) == 0) rz = ~rz;
      step(($urandom_range(7) == 0), rd, rb, rz, ($urandom_range(399) != 0));
    end
    idle(4);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
